// File: rtl/bcd_scan_display.sv
// bcd_scan_display: 4-digit multiplexed common-anode 7-segment driver with frame snapshot, LZ blanking, guard time and lamp test
module bcd_scan_display #(
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 16
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic [15:0] DIG,
  input  logic [3:0]  DP,
  input  logic        BLANK_LZ,
  input  logic        LAMP_TEST,
  output logic [6:0]  SEG_N,
  output logic        DP_N,
  output logic [3:0]  AN_N
);
  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);
  localparam logic [15:0] GMIN = 16'(GUARD);
  logic [15:0] pcnt_q, pcnt_d, snap_q, snap_d;
  logic [1:0]  scan_q, scan_d;
  logic [3:0]  snap_dp_q, snap_dp_d, an_n_q, an_n_d, lz, digit, an_sel;
  logic [6:0]  seg_n_q, seg_n_d;
  logic        dp_n_q, dp_n_d, tick, guard, blank, dp_on;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  endfunction
  always_comb begin
    tick      = pcnt_q == PMAX;
    pcnt_d    = tick ? 16'd0 : pcnt_q + 16'd1;
    scan_d    = tick ? scan_q + 2'd1 : scan_q;
    snap_d    = (tick && scan_q == 2'd3) ? DIG : snap_q;
    snap_dp_d = (tick && scan_q == 2'd3) ? DP : snap_dp_q;
    digit     = snap_q[{scan_q, 2'b00} +: 4];
    lz        = 4'b0000;
    lz[3]     = snap_q[15:12] == 4'd0;
    lz[2]     = lz[3] && snap_q[11:8] == 4'd0;
    lz[1]     = lz[2] && snap_q[7:4] == 4'd0;
    blank     = BLANK_LZ && lz[scan_q];
    dp_on     = snap_dp_q[scan_q];
    an_sel    = ~(4'b0001 << scan_q);
    guard     = pcnt_q < GMIN;
    seg_n_d   = guard ? 7'h7F : LAMP_TEST ? 7'h00 : blank ? 7'h7F : dec(digit);
    dp_n_d    = guard ? 1'b1 : LAMP_TEST ? 1'b0 : ~dp_on;
    // a blanked digit only lights its anode when it still has a decimal point to show
    an_n_d    = (guard || (!LAMP_TEST && blank && !dp_on)) ? 4'hF : an_sel;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      pcnt_q    <= 16'd0;
      scan_q    <= 2'd0;
      snap_q    <= 16'h0000;
      snap_dp_q <= 4'h0;
      seg_n_q   <= 7'h7F;
      dp_n_q    <= 1'b1;
      an_n_q    <= 4'hF;
    end else begin
      pcnt_q    <= pcnt_d;
      scan_q    <= scan_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      an_n_q    <= an_n_d;
    end
  end
  assign SEG_N = seg_n_q;
  assign DP_N  = dp_n_q;
  assign AN_N  = an_n_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: scoreboard bench, expected outputs queued per cycle and checked by a monitor
module tb_bcd_scan_display;
  logic        CLK, RESET_B, BLANK_LZ, LAMP_TEST, DP_N;
  logic [15:0] DIG;
  logic [3:0]  DP, AN_N;
  logic [6:0]  SEG_N;
  typedef struct {
    int         when;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    string      name;
  } exp_t;
  exp_t q[$];
  int cyc = 0, base = 0, errors = 0, checks = 0;
  bcd_scan_display #(.PRESCALE(4), .GUARD(1)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .DIG(DIG), .DP(DP), .BLANK_LZ(BLANK_LZ),
    .LAMP_TEST(LAMP_TEST), .SEG_N(SEG_N), .DP_N(DP_N), .AN_N(AN_N)
  );
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].when <= cyc) begin
      checks++;
      if (q[0].when < cyc) begin
        errors++;
        $display("FAIL %s: check at cycle %0d skipped (now %0d)", q[0].name, q[0].when, cyc);
      end else if (SEG_N !== q[0].seg || DP_N !== q[0].dp || AN_N !== q[0].an) begin
        errors++;
        $display("FAIL %s: got seg=%h dp=%b an=%h want seg=%h dp=%b an=%h",
                 q[0].name, SEG_N, DP_N, AN_N, q[0].seg, q[0].dp, q[0].an);
      end
      void'(q.pop_front());
    end
  end
  task automatic push(input int w, input logic [6:0] seg, input logic dp, input logic [3:0] an, input string nm);
    exp_t e;
    e.when = w; e.seg = seg; e.dp = dp; e.an = an; e.name = nm;
    q.push_back(e);
  endtask
  // one slot: a guard cycle with everything dark, then three driven cycles
  task automatic sl(input int f, input int s, input logic [11:0] v);
    int w;
    w = base + 16 * f + 4 * s;
    push(w + 1, 7'h7F, 1'b1, 4'hF, $sformatf("f%0d s%0d guard", f, s));
    for (int j = 2; j <= 4; j++)
      push(w + j, v[11:5], v[4], v[3:0], $sformatf("f%0d s%0d c%0d", f, s, j - 1));
  endtask
  task automatic fr(input int f, input logic [11:0] s0, input logic [11:0] s1, input logic [11:0] s2, input logic [11:0] s3);
    sl(f, 0, s0); sl(f, 1, s1); sl(f, 2, s2); sl(f, 3, s3);
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask
  task automatic do_reset();
    RESET_B = 0;
    push(cyc + 1, 7'h7F, 1'b1, 4'hF, "reset");
    @(negedge CLK);
    RESET_B = 1;
    base = cyc;
  endtask
  task automatic at_frame(input int f);
    wait_cyc(base + 16 * f);
  endtask
  initial begin
    RESET_B = 0; DIG = 16'h1234; DP = 4'h0; BLANK_LZ = 0; LAMP_TEST = 0;
    repeat (3) @(negedge CLK);
    do_reset();
    fr(0, {7'h40,1'b1,4'hE}, {7'h40,1'b1,4'hD}, {7'h40,1'b1,4'hB}, {7'h40,1'b1,4'h7});
    at_frame(1);
    fr(1, {7'h19,1'b1,4'hE}, {7'h30,1'b1,4'hD}, {7'h24,1'b1,4'hB}, {7'h79,1'b1,4'h7});
    DIG = 16'h0070; DP = 4'b0100;
    at_frame(2);
    BLANK_LZ = 1;
    fr(2, {7'h40,1'b1,4'hE}, {7'h78,1'b1,4'hD}, {7'h7F,1'b0,4'hB}, {7'h7F,1'b1,4'hF});
    DIG = 16'h0009; DP = 4'h0;
    at_frame(3);
    fr(3, {7'h10,1'b1,4'hE}, {7'h7F,1'b1,4'hF}, {7'h7F,1'b1,4'hF}, {7'h7F,1'b1,4'hF});
    wait_cyc(base + 48 + 6);
    DIG = 16'h0010;
    at_frame(4);
    fr(4, {7'h40,1'b1,4'hE}, {7'h79,1'b1,4'hD}, {7'h7F,1'b1,4'hF}, {7'h7F,1'b1,4'hF});
    DIG = 16'hF0A5;
    at_frame(5);
    fr(5, {7'h12,1'b1,4'hE}, {7'h3F,1'b1,4'hD}, {7'h40,1'b1,4'hB}, {7'h3F,1'b1,4'h7});
    DIG = 16'h0000;
    at_frame(6);
    LAMP_TEST = 1;
    fr(6, {7'h00,1'b0,4'hE}, {7'h00,1'b0,4'hD}, {7'h00,1'b0,4'hB}, {7'h00,1'b0,4'h7});
    at_frame(7);
    LAMP_TEST = 0;
    fr(7, {7'h40,1'b1,4'hE}, {7'h7F,1'b1,4'hF}, {7'h7F,1'b1,4'hF}, {7'h7F,1'b1,4'hF});
    DIG = 16'h1234;
    at_frame(8);
    BLANK_LZ = 0;
    sl(8, 0, {7'h19,1'b1,4'hE});
    sl(8, 1, {7'h30,1'b1,4'hD});
    push(base + 128 + 9, 7'h7F, 1'b1, 4'hF, "f8 s2 guard");
    wait_cyc(base + 128 + 9);
    do_reset();
    fr(0, {7'h40,1'b1,4'hE}, {7'h40,1'b1,4'hD}, {7'h40,1'b1,4'hB}, {7'h40,1'b1,4'h7});
    at_frame(1);
    fr(1, {7'h19,1'b1,4'hE}, {7'h30,1'b1,4'hD}, {7'h24,1'b1,4'hB}, {7'h79,1'b1,4'h7});
    wait_cyc(base + 32);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge CLK);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
